// File: rtl/rob_pkg.sv
// Shared constants and types for the reorder buffer.
// Tag width and entry record are used by the top and the query helper.
package rob_pkg;
    localparam int ROB_SIZE = 16;
    localparam int ROB_BIT  = 4;
    localparam logic [ROB_BIT:0] ROB_FULL_CNT = (ROB_BIT + 1)'(ROB_SIZE);

    typedef enum logic [1:0] {
        ROB_REG = 2'd0,
        ROB_BR  = 2'd1,
        ROB_ST  = 2'd2
    } rob_type_e;

    typedef struct packed {
        rob_type_e   kind;
        logic [4:0]  rd;
        logic        pred_taken;
        logic [31:0] inst_addr;
        logic [31:0] br_target;
    } rob_entry_t;
endpackage

// File: rtl/rob_query.sv
// Operand tag lookup: stored result, or this cycle's Alu/Lsb broadcast.
module rob_query
    import rob_pkg::*;
(
    input  logic [ROB_BIT-1:0]  i_entry,
    input  logic [ROB_SIZE-1:0] i_ready,
    input  logic [31:0]         i_value [ROB_SIZE],
    input  logic                i_rs_ready,
    input  logic [ROB_BIT-1:0]  i_rs_entry,
    input  logic [31:0]         i_rs_value,
    input  logic                i_lsb_ready,
    input  logic [ROB_BIT-1:0]  i_lsb_entry,
    input  logic [31:0]         i_lsb_value,
    output logic                o_ready,
    output logic [31:0]         o_value
);
    always_comb begin
        o_ready = i_ready[i_entry];
        o_value = i_value[i_entry];
        if (i_rs_ready && (i_rs_entry == i_entry)) begin
            o_ready = 1'b1;
            o_value = i_rs_value;
        end else if (i_lsb_ready && (i_lsb_entry == i_entry)) begin
            o_ready = 1'b1;
            o_value = i_lsb_value;
        end
    end
endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order retirement of out-of-order results, branch
// resolution at the head and a one-cycle flush pulse on mispredict.
module rob
    import rob_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               issue_valid,
    input  logic [1:0]         issue_type,
    input  logic [4:0]         issue_rd,
    input  logic               issue_pred_taken,
    input  logic [31:0]        issue_inst_addr,
    input  logic [31:0]        issue_br_target,
    output logic [ROB_BIT-1:0] tail_entry,
    output logic               is_full,
    input  logic               rs_ready,
    input  logic [ROB_BIT-1:0] rs_rob_entry,
    input  logic [31:0]        rs_value,
    input  logic               lsb_ready,
    input  logic [ROB_BIT-1:0] lsb_rob_entry,
    input  logic [31:0]        lsb_value,
    input  logic [ROB_BIT-1:0] query1_entry,
    output logic               query1_ready,
    output logic [31:0]        query1_value,
    input  logic [ROB_BIT-1:0] query2_entry,
    output logic               query2_ready,
    output logic [31:0]        query2_value,
    output logic               commit_valid,
    output logic [4:0]         commit_rd,
    output logic [31:0]        commit_value,
    output logic [ROB_BIT-1:0] commit_rob_entry,
    output logic               store_commit,
    output logic               rob_clear_up,
    output logic [31:0]        redirect_pc
);
    logic [ROB_BIT-1:0]  r_head;
    logic [ROB_BIT-1:0]  r_tail;
    logic [ROB_BIT:0]    r_count;
    logic                r_full;
    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_ready;
    logic [31:0]         r_value [ROB_SIZE];
    rob_entry_t          r_ent   [ROB_SIZE];

    logic             w_commit;
    logic             w_issue;
    logic             w_taken;
    logic [ROB_BIT:0] w_count_nxt;
    rob_entry_t       w_head;

    assign w_head   = r_ent[r_head];
    assign w_commit = r_busy[r_head] && r_ready[r_head];
    // A full buffer still accepts an issue when the head retires on the same edge.
    assign w_issue  = issue_valid && (!r_full || w_commit);
    assign w_taken  = r_value[r_head][0];
    assign w_count_nxt = r_count + {{ROB_BIT{1'b0}}, w_issue} - {{ROB_BIT{1'b0}}, w_commit};

    assign tail_entry = r_tail;
    assign is_full    = r_full;

    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && rob_clear_up)) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_full           <= 1'b0;
            r_busy           <= '0;
            r_ready          <= '0;
            commit_valid     <= 1'b0;
            commit_rd        <= '0;
            commit_value     <= '0;
            commit_rob_entry <= '0;
            store_commit     <= 1'b0;
            rob_clear_up     <= 1'b0;
            redirect_pc      <= '0;
        end else if (!rdy_in) begin
            commit_valid <= 1'b0;
            store_commit <= 1'b0;
        end else begin
            commit_valid <= w_commit;
            store_commit <= w_commit && (w_head.kind == ROB_ST);
            if (w_commit) begin
                r_busy[r_head]   <= 1'b0;
                r_ready[r_head]  <= 1'b0;
                r_head           <= r_head + 1'b1;
                commit_rd        <= (w_head.kind == ROB_REG) ? w_head.rd : 5'd0;
                commit_value     <= r_value[r_head];
                commit_rob_entry <= r_head;
                if ((w_head.kind == ROB_BR) && (w_taken != w_head.pred_taken)) begin
                    rob_clear_up <= 1'b1;
                    redirect_pc  <= w_taken ? w_head.br_target : w_head.inst_addr + 32'd4;
                end
            end
            if (rs_ready && r_busy[rs_rob_entry]) begin
                r_ready[rs_rob_entry] <= 1'b1;
                r_value[rs_rob_entry] <= rs_value;
            end
            if (lsb_ready && r_busy[lsb_rob_entry]) begin
                r_ready[lsb_rob_entry] <= 1'b1;
                r_value[lsb_rob_entry] <= lsb_value;
            end
            // Issue last so it wins when tail == head on a full-buffer retire.
            if (w_issue) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_ent[r_tail]   <= '{kind:       rob_type_e'(issue_type),
                                     rd:         issue_rd,
                                     pred_taken: issue_pred_taken,
                                     inst_addr:  issue_inst_addr,
                                     br_target:  issue_br_target};
                r_tail          <= r_tail + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == ROB_FULL_CNT);
        end
    end

    rob_query u_query1 (
        .i_entry     (query1_entry),
        .i_ready     (r_ready),
        .i_value     (r_value),
        .i_rs_ready  (rs_ready),
        .i_rs_entry  (rs_rob_entry),
        .i_rs_value  (rs_value),
        .i_lsb_ready (lsb_ready),
        .i_lsb_entry (lsb_rob_entry),
        .i_lsb_value (lsb_value),
        .o_ready     (query1_ready),
        .o_value     (query1_value)
    );

    rob_query u_query2 (
        .i_entry     (query2_entry),
        .i_ready     (r_ready),
        .i_value     (r_value),
        .i_rs_ready  (rs_ready),
        .i_rs_entry  (rs_rob_entry),
        .i_rs_value  (rs_value),
        .i_lsb_ready (lsb_ready),
        .i_lsb_entry (lsb_rob_entry),
        .i_lsb_value (lsb_value),
        .o_ready     (query2_ready),
        .o_value     (query2_value)
    );
endmodule
